// File: rtl/dl_pkg.sv
// Shared definitions for the download router: FSM state encoding and the
// default ioctl_index values used to tag ROM and config sessions.
package dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } dl_state_t;

  localparam int unsigned ROM_INDEX_DEF = 0;
  localparam int unsigned CFG_INDEX_DEF = 1;
  localparam int unsigned IOCTL_AW      = 25;

endpackage

// File: rtl/dl_router.sv
// Download router: steers ioctl ROM bytes into per-region write strobes,
// captures the title/config byte, and holds the game core in reset while a
// ROM session is in progress and for HOLD_CYCLES cycles afterwards.
module dl_router
  import dl_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned REGION_AW   = 14,
  parameter int unsigned ROM_INDEX   = ROM_INDEX_DEF,
  parameter int unsigned CFG_INDEX   = CFG_INDEX_DEF,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [7:0]             ioctl_index,
  output logic [NUM_REGIONS-1:0] dn_we,
  output logic [REGION_AW-1:0]   dn_addr,
  output logic [7:0]             dn_data,
  output logic [7:0]             cfg_byte,
  output logic                   core_reset,
  output logic                   dl_done,
  output logic                   dl_error,
  output logic [24:0]            byte_count,
  output logic [7:0]             checksum
);

  localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  dl_state_t        state, state_n;
  logic [HCW-1:0]   hold_cnt, hold_n;
  logic             start_sess;
  logic             done_n;
  logic             rom_wr;
  logic             bad_wr;
  logic             idx_rom;
  logic             cfg_wr;
  logic [24:0]      region;
  logic             in_range;
  logic [NUM_REGIONS-1:0] we_dec;

  assign idx_rom  = (ioctl_index == 8'(ROM_INDEX));
  assign cfg_wr   = ioctl_wr && (ioctl_index == 8'(CFG_INDEX)) && (ioctl_addr == '0);
  assign region   = ioctl_addr >> REGION_AW;
  assign in_range = (region < 25'(NUM_REGIONS));

  // One-hot decode of the target region for the write strobe.
  always_comb begin
    we_dec = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      we_dec[i] = (region == 25'(i));
    end
  end

  // Next-state logic: session start/restart, write classification, hold timer.
  always_comb begin
    state_n    = state;
    hold_n     = hold_cnt;
    start_sess = 1'b0;
    done_n     = 1'b0;
    rom_wr     = 1'b0;
    bad_wr     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ioctl_download && idx_rom) begin
          state_n    = ST_LOAD;
          start_sess = 1'b1;
          hold_n     = '0;
        end
      end
      ST_LOAD: begin
        if (ioctl_wr && idx_rom) begin
          if (in_range) rom_wr = 1'b1;
          else          bad_wr = 1'b1;
        end
        if (!ioctl_download) begin
          state_n = ST_HOLD;
          hold_n  = '0;
        end
      end
      ST_HOLD: begin
        // A new ROM session wins over hold expiry, so no dl_done is emitted.
        if (ioctl_download && idx_rom) begin
          state_n    = ST_LOAD;
          start_sess = 1'b1;
          hold_n     = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          hold_n  = '0;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        hold_n  = '0;
      end
    endcase
  end

  // State register, hold counter and status outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      core_reset <= 1'b0;
      dl_done    <= 1'b0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_n;
      core_reset <= (state_n != ST_IDLE);
      dl_done    <= done_n;
    end
  end

  // Registered region write port; address/data hold their last value.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dn_we   <= '0;
      dn_addr <= '0;
      dn_data <= '0;
    end else begin
      dn_we <= rom_wr ? we_dec : '0;
      if (rom_wr) begin
        dn_addr <= ioctl_addr[REGION_AW-1:0];
        dn_data <= ioctl_dout;
      end
    end
  end

  // Session statistics: cleared on session start, saturating byte count.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      byte_count <= '0;
      checksum   <= '0;
      dl_error   <= 1'b0;
    end else if (start_sess) begin
      byte_count <= '0;
      checksum   <= '0;
      dl_error   <= 1'b0;
    end else begin
      if (rom_wr) begin
        if (byte_count != '1) byte_count <= byte_count + 1'b1;
        checksum <= checksum + ioctl_dout;
      end
      if (bad_wr) dl_error <= 1'b1;
    end
  end

  // Title/config byte capture, independent of the ROM session state.
  always_ff @(posedge clk_sys) begin
    if (reset)       cfg_byte <= '0;
    else if (cfg_wr) cfg_byte <= ioctl_dout;
  end

endmodule

// File: doc/dl_router.md
DL_ROUTER -- requirements
Module: dl_router

Interface
REQ-001 Parameter NUM_REGIONS, default 4, number of ROM target regions (1..8).
REQ-002 Parameter REGION_AW, default 14, address width of each region; region size 2^REGION_AW bytes.
REQ-003 Parameter ROM_INDEX, default 0, ioctl_index value carrying ROM data.
REQ-004 Parameter CFG_INDEX, default 1, ioctl_index value carrying the title/config byte.
REQ-005 Parameter HOLD_CYCLES, default 16, post-download reset extension in clk_sys cycles (>=1).
REQ-006 clk_sys  in  1  system clock; all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 ioctl_download  in  1  download session active.
REQ-009 ioctl_wr  in  1  one-cycle byte strobe.
REQ-010 ioctl_addr  in  25  byte address within session.
REQ-011 ioctl_dout  in  8  byte data.
REQ-012 ioctl_index  in  8  session index.
REQ-013 dn_we  out  NUM_REGIONS  one-hot region write strobe.
REQ-014 dn_addr  out  REGION_AW  address within selected region.
REQ-015 dn_data  out  8  write data.
REQ-016 cfg_byte  out  8  last config byte.
REQ-017 core_reset  out  1  hold game core in reset.
REQ-018 dl_done  out  1  one-cycle pulse at end of ROM load.
REQ-019 dl_error  out  1  sticky: out-of-range write seen this session.
REQ-020 byte_count  out  25  ROM bytes accepted this session.
REQ-021 checksum  out  8  mod-256 sum of accepted ROM bytes.

Function
REQ-022 States IDLE, LOAD, HOLD; IDLE->LOAD when ioctl_download=1 and ioctl_index=ROM_INDEX; LOAD->HOLD when ioctl_download=0; HOLD->IDLE after HOLD_CYCLES cycles.
REQ-023 On IDLE->LOAD: byte_count, checksum, dl_error cleared same edge.
REQ-024 In LOAD, ioctl_wr with region r = ioctl_addr>>REGION_AW < NUM_REGIONS: next cycle dn_we[r]=1, dn_addr=ioctl_addr[REGION_AW-1:0], dn_data=ioctl_dout (1-cycle latency, registered); byte_count +1, checksum += byte.
REQ-025 In LOAD, ioctl_wr with r >= NUM_REGIONS: no dn_we, counters unchanged, dl_error set.
REQ-026 dn_we zero in every cycle not following an accepted write; dn_addr/dn_data hold last value.
REQ-027 ioctl_wr with ioctl_index=CFG_INDEX and ioctl_addr=0, in any state: cfg_byte<=ioctl_dout next cycle; other CFG_INDEX addresses ignored.
REQ-028 core_reset=1 in LOAD and HOLD, 0 in IDLE; registered.
REQ-029 dl_done=1 for exactly the cycle of HOLD->IDLE.
REQ-030 ioctl_download rising with another index is ignored: state stays IDLE.
REQ-031 ioctl_wr in IDLE or HOLD with ROM_INDEX: ignored.
REQ-032 byte_count saturates at 2^25-1; checksum wraps mod 256.
REQ-033 ioctl_download re-asserted during HOLD (ROM_INDEX): HOLD->LOAD, counters cleared, no dl_done.

Reset
REQ-034 On reset: state IDLE, dn_we=0, dn_addr=0, dn_data=0, cfg_byte=0, core_reset=0, dl_done=0, dl_error=0, byte_count=0, checksum=0, hold counter 0.
REQ-035 Reset mid-LOAD or mid-HOLD aborts: no dl_done; next session starts clean.

Structure
REQ-036 State enum and index constants (ROM_INDEX, CFG_INDEX defaults) in shared package dl_pkg.
REQ-037 Single module; hold counter inline, no sub-modules.

Verification
REQ-038 Download idx 0, bytes 0x11,0x22 at addr 0x0000, 0x4001 -> dn_we=0001 addr 0 data 0x11, then dn_we=0010 addr 1 data 0x22; byte_count=2, checksum=0x33.
REQ-039 Write addr 0x10000 (region 4, NUM_REGIONS=4) -> no dn_we, dl_error=1, byte_count unchanged.
REQ-040 Idx 1 write 0x05 at addr 0 -> cfg_byte=0x05; at addr 3 -> cfg_byte unchanged; core_reset stays 0.
REQ-041 ioctl_download falls -> core_reset high 16 more cycles, dl_done pulses once, then core_reset=0.
REQ-042 Reset asserted during LOAD -> all outputs to REQ-034 values, no dl_done.
REQ-043 Second download started during HOLD -> back to LOAD, counters 0, dl_error 0, no dl_done between.
